// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and constants for the SimpleRISC five-stage pipeline.
package pipe_ctrl_pkg;
  localparam int REG_W = 5;
  // SimpleRISC nop encoding (opcode 01101), loaded by pipeline registers on flush/bubble.
  localparam logic [31:0] NOP = 32'h6800_0000;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the OF sources and the ALU-stage load destination.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs1_OF,
  input  logic [REG_W-1:0] rs2_OF,
  input  logic             uses_rs1_OF,
  input  logic             uses_rs2_OF,
  input  logic             is_Ld_ALU,
  input  logic             isWb_ALU,
  input  logic [REG_W-1:0] rd_ALU,
  output logic             hazard
);
  // r0 is compared like any other register.
  assign hazard = is_Ld_ALU & isWb_ALU &
                  ((uses_rs1_OF & (rs1_OF == rd_ALU)) |
                   (uses_rs2_OF & (rs2_OF == rd_ALU)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: memory wait FSM with timeout, taken-branch flush and load-use bubble.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1_OF,
  input  logic [REG_W-1:0] rs2_OF,
  input  logic             uses_rs1_OF,
  input  logic             uses_rs2_OF,
  input  logic             is_Ld_ALU,
  input  logic [REG_W-1:0] rd_ALU,
  input  logic             isWb_ALU,
  input  logic             branch_taken_ALU,
  input  logic             is_Ld_DM,
  input  logic             is_St_DM,
  input  logic             mem_ready,
  output logic             stall_IFOF,
  output logic             stall_OFALU,
  output logic             stall_ALUDM,
  output logic             stall_DMWB,
  output logic             flush_IFOF,
  output logic             bubble_ALU,
  output logic             bubble_WB,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t          state;
  logic [WC_W-1:0] wcnt;
  logic            lu_hazard;
  logic            req_raw, timeout, mem_stall, br, lu;

  load_use_detect u_lud (
    .rs1_OF      (rs1_OF),
    .rs2_OF      (rs2_OF),
    .uses_rs1_OF (uses_rs1_OF),
    .uses_rs2_OF (uses_rs2_OF),
    .is_Ld_ALU   (is_Ld_ALU),
    .isWb_ALU    (isWb_ALU),
    .rd_ALU      (rd_ALU),
    .hazard      (lu_hazard)
  );

  always_comb begin
    req_raw   = (state == WAIT) | is_Ld_DM | is_St_DM;
    timeout   = (state == WAIT) & ~mem_ready & (wcnt == WC_W'(TIMEOUT - 1));
    mem_stall = req_raw & ~mem_ready & ~timeout;
    // Memory freeze outranks branch, which outranks load-use.
    br        = ~mem_stall & branch_taken_ALU;
    lu        = ~mem_stall & ~branch_taken_ALU & lu_hazard;
  end

  // Every output is forced low while reset is held, including mid-WAIT.
  assign stall_IFOF  = rst_n & (mem_stall | lu);
  assign stall_OFALU = rst_n & (mem_stall | lu);
  assign stall_ALUDM = rst_n & mem_stall;
  assign stall_DMWB  = rst_n & mem_stall;
  assign bubble_WB   = rst_n & mem_stall;
  assign flush_IFOF  = rst_n & br;
  assign bubble_ALU  = rst_n & (br | lu);
  assign mem_req     = rst_n & req_raw;
  assign mem_we      = rst_n & req_raw & is_St_DM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_raw && !mem_ready) begin
          state <= WAIT;
          wcnt  <= WC_W'(1);
        end
        WAIT: if (mem_ready) begin
          state <= IDLE;
          wcnt  <= '0;
        end else if (timeout) begin
          state   <= IDLE;
          wcnt    <= '0;
          mem_err <= 1'b1;
        end else begin
          wcnt <= wcnt + WC_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (stall_IFOF && stall_cycles != '1)
      stall_cycles <= stall_cycles + CNT_W'(1);
  end
endmodule
